// File: rtl/adc_scanner.sv
// adc_scanner: multi-channel ADS1115 scanner. While enabled it walks MUX_LIST, runs one
// single-shot conversion per channel over the shared byte-level I2C master, polls the OS bit
// with a bounded retry count, and streams each result out tagged with its channel index.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   enable_i              level; scanning continues while high
//   pga_i                 PGA code, sampled when each channel starts
//   data_o / channel_o    last result and the channel it belongs to
//   data_valid_o          one-cycle pulse when a result is published
//   timeout_o             one-cycle pulse when a channel never finished converting
//   busy_o                high whenever the FSM is not idle
//   i2c_*                 instruction/enable/complete handshake to the I2C master
module adc_scanner #(
  parameter logic [6:0]                ADDRESS      = 7'd72,
  parameter int unsigned               NUM_CHANNELS = 4,
  parameter logic [3*NUM_CHANNELS-1:0] MUX_LIST     = {3'b111, 3'b110, 3'b101, 3'b100},
  parameter int unsigned               POLL_DELAY   = 256,
  parameter int unsigned               MAX_POLLS    = 16,
  localparam int unsigned              CH_W         = (NUM_CHANNELS > 1) ?
                                                      $clog2(NUM_CHANNELS) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic [2:0]      pga_i,
  output logic [15:0]     data_o,
  output logic [CH_W-1:0] channel_o,
  output logic            data_valid_o,
  output logic            timeout_o,
  output logic            busy_o,
  output logic [1:0]      i2c_instruction_o,
  output logic            i2c_enable_o,
  output logic [7:0]      i2c_byte_to_send_o,
  input  logic [7:0]      i2c_byte_received_i,
  input  logic            i2c_complete_i
);

  localparam int unsigned DW       = $clog2(POLL_DELAY + 1);
  localparam int unsigned PW       = $clog2(MAX_POLLS + 1);
  localparam int unsigned NumSlots = 2 ** CH_W;
  // Pad the list to a power-of-two table so any ch_q value indexes in range.
  localparam logic [3*NumSlots-1:0] MuxExt = (3 * NumSlots)'(MUX_LIST);

  localparam logic [1:0] InstrStart = 2'd0;
  localparam logic [1:0] InstrStop  = 2'd1;
  localparam logic [1:0] InstrRead  = 2'd2;
  localparam logic [1:0] InstrWrite = 2'd3;

  localparam logic [1:0] CapNone   = 2'd0;
  localparam logic [1:0] CapStatus = 2'd1;
  localparam logic [1:0] CapMsb    = 2'd2;
  localparam logic [1:0] CapLsb    = 2'd3;

  typedef enum logic [2:0] {
    StIdle, StConfig, StDelay, StPoll, StCheck, StFetch, StEmit, StNext
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic            seen_low_q, seen_low_d;
  logic            en_q, en_d;
  logic [1:0]      instr_q, instr_d;
  logic [7:0]      byte_q, byte_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [2:0]      pga_q, pga_d;
  logic [PW-1:0]   polls_q, polls_d;
  logic [DW-1:0]   delay_q, delay_d;
  logic [7:0]      status_q, status_d;
  logic [7:0]      msb_q, msb_d;
  logic [7:0]      lsb_q, lsb_d;
  logic [15:0]     data_q, data_d;
  logic [CH_W-1:0] channel_q, channel_d;
  logic            dv_q, dv_d;
  logic            to_q, to_d;
  logic            busy_q, busy_d;

  logic [2:0] mux_tbl [NumSlots];
  logic [1:0] op_instr;
  logic [7:0] op_byte;
  logic       op_last;
  logic [1:0] op_cap;

  always_comb begin
    for (int k = 0; k < NumSlots; k++) begin
      mux_tbl[k] = MuxExt[3*k +: 3];
    end
  end

  // Instruction table for the current op of each bus sequence.
  always_comb begin
    op_instr = InstrStart;
    op_byte  = 8'h00;
    op_last  = 1'b0;
    op_cap   = CapNone;
    case (state_q)
      StConfig: begin
        case (op_q)
          4'd0:    op_instr = InstrStart;
          4'd1:    begin op_instr = InstrWrite; op_byte = {ADDRESS, 1'b0}; end
          4'd2:    begin op_instr = InstrWrite; op_byte = 8'h01; end
          4'd3:    begin
            op_instr = InstrWrite;
            op_byte  = {1'b1, mux_tbl[ch_q], pga_q, 1'b1};
          end
          4'd4:    begin op_instr = InstrWrite; op_byte = 8'h83; end
          default: begin op_instr = InstrStop; op_last = 1'b1; end
        endcase
      end
      StPoll: begin
        case (op_q)
          4'd0:    op_instr = InstrStart;
          4'd1:    begin op_instr = InstrWrite; op_byte = {ADDRESS, 1'b1}; end
          4'd2:    begin op_instr = InstrRead; op_cap = CapStatus; end
          4'd3:    op_instr = InstrRead;
          default: begin op_instr = InstrStop; op_last = 1'b1; end
        endcase
      end
      StFetch: begin
        case (op_q)
          4'd0:    op_instr = InstrStart;
          4'd1:    begin op_instr = InstrWrite; op_byte = {ADDRESS, 1'b0}; end
          4'd2:    begin op_instr = InstrWrite; op_byte = 8'h00; end
          4'd3:    op_instr = InstrStop;
          4'd4:    op_instr = InstrStart;
          4'd5:    begin op_instr = InstrWrite; op_byte = {ADDRESS, 1'b1}; end
          4'd6:    begin op_instr = InstrRead; op_cap = CapMsb; end
          4'd7:    begin op_instr = InstrRead; op_cap = CapLsb; end
          default: begin op_instr = InstrStop; op_last = 1'b1; end
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    seen_low_d = seen_low_q;
    en_d       = en_q;
    instr_d    = instr_q;
    byte_d     = byte_q;
    ch_d       = ch_q;
    pga_d      = pga_q;
    polls_d    = polls_q;
    delay_d    = delay_q;
    status_d   = status_q;
    msb_d      = msb_q;
    lsb_d      = lsb_q;
    data_d     = data_q;
    channel_d  = channel_q;
    dv_d       = 1'b0;
    to_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          ch_d    = '0;
          pga_d   = pga_i;
          op_d    = 4'd0;
          state_d = StConfig;
        end
      end
      StConfig, StPoll, StFetch: begin
        if (!en_q) begin
          // Issue cycle: instruction and byte stay frozen until the op completes.
          en_d       = 1'b1;
          instr_d    = op_instr;
          byte_d     = op_byte;
          seen_low_d = 1'b0;
        end else if (!i2c_complete_i) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          en_d = 1'b0;
          case (op_cap)
            CapStatus: status_d = i2c_byte_received_i;
            CapMsb:    msb_d    = i2c_byte_received_i;
            CapLsb:    lsb_d    = i2c_byte_received_i;
            default:   ;
          endcase
          if (op_last) begin
            op_d = 4'd0;
            if (state_q == StConfig) begin
              polls_d = '0;
              delay_d = '0;
              state_d = StDelay;
            end else if (state_q == StPoll) begin
              polls_d = polls_q + PW'(1);
              state_d = StCheck;
            end else begin
              state_d = StEmit;
            end
          end else begin
            op_d = op_q + 4'd1;
          end
        end
      end
      StDelay: begin
        if (delay_q == DW'(POLL_DELAY - 1)) begin
          delay_d = '0;
          state_d = StPoll;
        end else begin
          delay_d = delay_q + DW'(1);
        end
      end
      StCheck: begin
        if (status_q[7]) begin
          state_d = StFetch;
        end else if (polls_q == PW'(MAX_POLLS)) begin
          to_d      = 1'b1;
          channel_d = ch_q;
          state_d   = StNext;
        end else begin
          state_d = StDelay;
        end
      end
      StEmit: begin
        data_d    = {msb_q, lsb_q};
        channel_d = ch_q;
        dv_d      = 1'b1;
        state_d   = StNext;
      end
      StNext: begin
        ch_d = (ch_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : ch_q + CH_W'(1);
        if (enable_i) begin
          pga_d   = pga_i;
          state_d = StConfig;
        end else begin
          state_d = StIdle;
        end
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      op_q       <= 4'd0;
      seen_low_q <= 1'b0;
      en_q       <= 1'b0;
      instr_q    <= 2'd0;
      byte_q     <= 8'h00;
      ch_q       <= '0;
      pga_q      <= 3'd0;
      polls_q    <= '0;
      delay_q    <= '0;
      status_q   <= 8'h00;
      msb_q      <= 8'h00;
      lsb_q      <= 8'h00;
      data_q     <= 16'h0000;
      channel_q  <= '0;
      dv_q       <= 1'b0;
      to_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      seen_low_q <= seen_low_d;
      en_q       <= en_d;
      instr_q    <= instr_d;
      byte_q     <= byte_d;
      ch_q       <= ch_d;
      pga_q      <= pga_d;
      polls_q    <= polls_d;
      delay_q    <= delay_d;
      status_q   <= status_d;
      msb_q      <= msb_d;
      lsb_q      <= lsb_d;
      data_q     <= data_d;
      channel_q  <= channel_d;
      dv_q       <= dv_d;
      to_q       <= to_d;
      busy_q     <= busy_d;
    end
  end

  assign data_o             = data_q;
  assign channel_o          = channel_q;
  assign data_valid_o       = dv_q;
  assign timeout_o          = to_q;
  assign busy_o             = busy_q;
  assign i2c_instruction_o  = instr_q;
  assign i2c_enable_o       = en_q;
  assign i2c_byte_to_send_o = byte_q;

endmodule

// File: tb/tb_adc_scanner.sv
// Self-checking bench for adc_scanner: a behavioural ADS1115 + I2C master model answers bus
// ops; each planned channel pushes its expected outcome into a scoreboard that a monitor
// drains on every data_valid/timeout pulse.
module tb_adc_scanner;

  localparam int unsigned NCH = 4;
  localparam int unsigned PD  = 4;
  localparam int unsigned MP  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  pga;
  logic [15:0] data;
  logic [1:0]  channel;
  logic        dv, to, busy;
  logic [1:0]  instr;
  logic        i2c_en;
  logic [7:0]  tx, rx;
  logic        cpl;

  always #5 clk = ~clk;

  adc_scanner #(
    .NUM_CHANNELS (NCH),
    .POLL_DELAY   (PD),
    .MAX_POLLS    (MP)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .enable_i            (enable),
    .pga_i               (pga),
    .data_o              (data),
    .channel_o           (channel),
    .data_valid_o        (dv),
    .timeout_o           (to),
    .busy_o              (busy),
    .i2c_instruction_o   (instr),
    .i2c_enable_o        (i2c_en),
    .i2c_byte_to_send_o  (tx),
    .i2c_byte_received_i (rx),
    .i2c_complete_i      (cpl)
  );

  typedef struct {bit is_to; int ch; logic [15:0] data; int polls;} exp_t;
  typedef struct {int ch; int zeros; logic [15:0] data; logic [2:0] pga;} plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    errors = 0;
  int    checks = 0;
  logic [15:0] model_last = 16'h0000;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  function automatic logic [2:0] mux_of(int ch);
    logic [11:0] l;
    l = {3'b111, 3'b110, 3'b101, 3'b100};
    return l[3*ch +: 3];
  endfunction

  // ---------------- ADS1115 + I2C master model ----------------
  int          sl_lat;
  bit          sl_busy, sl_done;
  int          byte_idx, read_idx;
  logic [7:0]  ptr, last_addr;
  plan_t       cur;
  int          zeros_left;
  int          cur_polls = 0;
  int          fetch_cnt = 0;

  task automatic slave_reset();
    cpl      = 1'b1;
    sl_busy  = 1'b0;
    sl_done  = 1'b0;
    byte_idx = 0;
    read_idx = 0;
    ptr      = 8'h00;
  endtask

  task automatic do_op();
    logic [7:0] b;
    b = tx;
    case (instr)
      2'd0: begin byte_idx = 0; read_idx = 0; end
      2'd3: begin
        if (byte_idx == 0) begin
          last_addr = b;
          check("i2c_addr", {25'd0, b[7:1]}, 32'd72);
        end else if (byte_idx == 1) begin
          check("addr_before_ptr", {24'd0, last_addr}, 32'h90);
          ptr = b;
          if (b == 8'h00) fetch_cnt++;
        end else if (ptr == 8'h01 && byte_idx == 2) begin
          if (plan_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cfg_unplanned: got config 0x%0h expected no conversion", b);
          end else begin
            cur        = plan_q.pop_front();
            zeros_left = cur.zeros;
            cur_polls  = 0;
            check("cfg_msb", {24'd0, b}, {24'd0, 1'b1, mux_of(cur.ch), cur.pga, 1'b1});
          end
        end else if (ptr == 8'h01 && byte_idx == 3) begin
          check("cfg_lsb", {24'd0, b}, 32'h83);
        end
        byte_idx++;
      end
      2'd2: begin
        if (read_idx == 0) check("addr_before_read", {24'd0, last_addr}, 32'h91);
        if (ptr == 8'h01) begin
          if (read_idx == 0) begin
            cur_polls++;
            if (zeros_left > 0) begin
              rx = 8'h00;
              zeros_left--;
            end else begin
              rx = 8'h80;
            end
          end else begin
            rx = 8'h83;
          end
        end else begin
          rx = (read_idx == 0) ? cur.data[15:8] : cur.data[7:0];
        end
        read_idx++;
      end
      default: ;
    endcase
  endtask

  initial begin
    rx = 8'h00;
    slave_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        slave_reset();
      end else if (sl_busy) begin
        if (sl_lat > 0) begin
          sl_lat--;
        end else if (!sl_done) begin
          do_op();
          cpl     = 1'b1;
          sl_done = 1'b1;
        end else if (!i2c_en) begin
          sl_busy = 1'b0;
        end
      end else if (i2c_en) begin
        cpl     = 1'b0;
        sl_lat  = $urandom_range(0, 2);
        sl_busy = 1'b1;
        sl_done = 1'b0;
      end
    end
  end

  // ---------------- Monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (dv || to)) begin
        if (dv && to) begin
          checks++;
          errors++;
          $display("FAIL pulse_overlap: got dv=1 to=1 expected one pulse");
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got dv=%0b to=%0b ch=%0d expected none", dv, to, channel);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {31'd0, to}, {31'd0, e.is_to});
          check("channel", {30'd0, channel}, e.ch);
          check("data", {16'd0, data}, {16'd0, e.data});
          check("polls", cur_polls, e.polls);
        end
      end
    end
  end

  // ---------------- Reference model / stimulus ----------------
  task automatic add_chan(int ch, int zeros, logic [15:0] d);
    plan_t p;
    exp_t  e;
    p.ch = ch; p.zeros = zeros; p.data = d; p.pga = pga;
    plan_q.push_back(p);
    e.ch = ch;
    if (zeros >= MP) begin
      e.is_to = 1'b1; e.data = model_last; e.polls = MP;
    end else begin
      e.is_to = 1'b0; e.data = d; e.polls = zeros + 1;
      model_last = d;
    end
    exp_q.push_back(e);
  endtask

  task automatic run_scan(bit drop_in_fetch);
    int t, f0;
    enable = 1'b1;
    t = 0;
    while (plan_q.size() != 0 && t < 20000) begin @(negedge clk); t++; end
    if (t >= 20000) fail_now("plans_consumed");
    if (drop_in_fetch) begin
      f0 = fetch_cnt;
      t = 0;
      while (fetch_cnt == f0 && t < 5000) begin @(negedge clk); t++; end
      if (t >= 5000) fail_now("reach_fetch");
    end
    enable = 1'b0;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 20000) begin @(negedge clk); t++; end
    check("busy_after_scan", {31'd0, busy}, 32'd0);
    check("results_left", exp_q.size(), 0);
    repeat (20) @(negedge clk);
    check("still_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_data"}, {16'd0, data}, 32'd0);
    check({tag, "_channel"}, {30'd0, channel}, 32'd0);
    check({tag, "_dv"}, {31'd0, dv}, 32'd0);
    check({tag, "_to"}, {31'd0, to}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_i2c_en"}, {31'd0, i2c_en}, 32'd0);
    check({tag, "_instr"}, {30'd0, instr}, 32'd0);
    check({tag, "_tx"}, {24'd0, tx}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t;
    rst = 1'b1; enable = 1'b0; pga = 3'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Four-channel scan, two passes: config MSBs C3/D3/E3/F3 with pga=1.
    pga = 3'b001;
    for (int k = 0; k < 8; k++) add_chan(k % NCH, 0, 16'h1000 + 16'(k % NCH));
    run_scan(1'b0);

    // Slow conversion on ch0, timeout on ch1, scan continues to ch2/ch3.
    pga = 3'b010;
    add_chan(0, 3, 16'($urandom));
    add_chan(1, 99, 16'($urandom));
    add_chan(2, 0, 16'($urandom));
    add_chan(3, 1, 16'($urandom));
    run_scan(1'b0);

    // Deassert during channel 2's fetch, then a fresh assert restarts at channel 0.
    pga = 3'b111;
    add_chan(0, 0, 16'($urandom));
    add_chan(1, 2, 16'($urandom));
    add_chan(2, 0, 16'($urandom));
    run_scan(1'b1);
    add_chan(0, 0, 16'($urandom));
    add_chan(1, 0, 16'($urandom));
    run_scan(1'b0);

    // Randomized scans.
    for (int r = 0; r < 4; r++) begin
      pga = 3'($urandom);
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) add_chan(k % NCH, $urandom_range(0, 5), 16'($urandom));
      run_scan(1'b0);
    end

    // Reset in the middle of a POLL sequence.
    cur_polls = 0;
    add_chan(0, 99, 16'hBEEF);
    enable = 1'b1;
    t = 0;
    while (cur_polls < 1 && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) fail_now("reach_poll");
    rst = 1'b1; enable = 1'b0;
    slave_reset();
    plan_q.delete();
    exp_q.delete();
    model_last = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midreset");
    repeat (5) @(negedge clk);

    // Recovery after reset.
    pga = 3'b100;
    add_chan(0, 1, 16'($urandom));
    add_chan(1, 0, 16'($urandom));
    run_scan(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
